// File: rtl/bypass_scoreboard_ex.sv
// EX-stage operand bypass with prioritised forwarding taps, tagged writeback and
// a per-register pending scoreboard that stalls EX on unresolved producers.

module bypass_scoreboard_ex_res #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int STAGES = 2,
  parameter int RW     = $clog2(NREG)
) (
  input  logic [RW-1:0]          src,
  input  logic [XLEN-1:0]        rf_data,
  input  logic [STAGES-1:0]      tap_valid,
  input  logic [STAGES-1:0]      tap_ready,
  input  logic [STAGES*RW-1:0]   tap_rd,
  input  logic [STAGES*XLEN-1:0] tap_data,
  input  logic                   wb_hit,
  input  logic [RW-1:0]          wb_rd,
  input  logic [XLEN-1:0]        wb_data,
  input  logic [NREG-1:0]        pending,
  output logic [XLEN-1:0]        val,
  output logic                   hazard
);
  logic found;

  always_comb begin
    val    = rf_data;
    hazard = 1'b0;
    found  = 1'b0;
    if (src == '0) begin
      val = '0;
    end else begin
      // youngest tap wins; a not-ready match blocks older sources entirely
      for (int i = 0; i < STAGES; i++) begin
        if (!found && tap_valid[i] && tap_rd[i*RW +: RW] == src) begin
          found = 1'b1;
          if (tap_ready[i]) val = tap_data[i*XLEN +: XLEN];
          else              hazard = 1'b1;
        end
      end
      if (!found) begin
        if (wb_hit && wb_rd == src) val = wb_data;
        else if (pending[src])      hazard = 1'b1;
      end
    end
  end
endmodule

module bypass_scoreboard_ex #(
  parameter int XLEN      = 32,
  parameter int NREG      = 32,
  parameter int STAGES    = 2,
  parameter int TAGW      = 3,
  parameter int MAX_STALL = 64,
  localparam int RW       = $clog2(NREG),
  localparam int CW       = $clog2(NREG+1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   idex_valid,
  input  logic [RW-1:0]          idex_rs1,
  input  logic [RW-1:0]          idex_rs2,
  input  logic [XLEN-1:0]        idex_rdA,
  input  logic [XLEN-1:0]        idex_rdB,
  input  logic                   idex_use_imm_a,
  input  logic                   issue_we,
  input  logic [RW-1:0]          issue_rd,
  input  logic [TAGW-1:0]        issue_tag,
  input  logic [STAGES-1:0]      tap_valid,
  input  logic [STAGES-1:0]      tap_ready,
  input  logic [STAGES*RW-1:0]   tap_rd,
  input  logic [STAGES*XLEN-1:0] tap_data,
  input  logic                   wb_valid,
  input  logic [RW-1:0]          wb_rd,
  input  logic [TAGW-1:0]        wb_tag,
  input  logic [XLEN-1:0]        wb_data,
  output logic [XLEN-1:0]        bypassOutA,
  output logic [XLEN-1:0]        bypassOutB,
  output logic                   stall,
  output logic [CW-1:0]          pending_cnt,
  output logic [15:0]            stall_cycles,
  output logic                   hazard_timeout
);
  logic [NREG-1:0]            pending_q, pending_d;
  logic [NREG-1:0][TAGW-1:0]  tag_q, tag_d;
  logic [CW-1:0]              pending_cnt_q, pending_cnt_d;
  logic [15:0]                stall_cycles_q, stall_cycles_d;
  logic                       hazard_timeout_q, hazard_timeout_d;

  logic                       wb_hit, issue_fire, haz_a;
  logic [1:0][RW-1:0]         src;
  logic [1:0][XLEN-1:0]       rf, val;
  logic [1:0]                 haz;

  // a writeback only counts if it belongs to the current owner of the register
  assign wb_hit     = wb_valid && wb_rd != '0 && pending_q[wb_rd] && tag_q[wb_rd] == wb_tag;
  assign issue_fire = idex_valid && issue_we && issue_rd != '0 && !stall;

  assign src = {idex_rs2, idex_rs1};
  assign rf  = {idex_rdB, idex_rdA};

  for (genvar g = 0; g < 2; g++) begin : g_res
    bypass_scoreboard_ex_res #(.XLEN(XLEN), .NREG(NREG), .STAGES(STAGES), .RW(RW)) u_res (
      .src(src[g]), .rf_data(rf[g]),
      .tap_valid(tap_valid), .tap_ready(tap_ready), .tap_rd(tap_rd), .tap_data(tap_data),
      .wb_hit(wb_hit), .wb_rd(wb_rd), .wb_data(wb_data), .pending(pending_q),
      .val(val[g]), .hazard(haz[g])
    );
  end

  assign bypassOutA = idex_use_imm_a ? XLEN'(idex_rs1) : val[0];
  assign bypassOutB = val[1];
  assign haz_a      = !idex_use_imm_a && haz[0];
  assign stall      = idex_valid && (haz_a || haz[1]);

  always_comb begin
    pending_d = pending_q;
    tag_d     = tag_q;
    if (wb_hit) pending_d[wb_rd] = 1'b0;
    // issue applied last so it wins over a same-cycle clear
    if (issue_fire) begin
      pending_d[issue_rd] = 1'b1;
      tag_d[issue_rd]     = issue_tag;
    end
    pending_d[0] = 1'b0;
    pending_cnt_d = '0;
    for (int r = 0; r < NREG; r++) pending_cnt_d = pending_cnt_d + CW'(pending_d[r]);
    if (!stall)                        stall_cycles_d = '0;
    else if (stall_cycles_q == 16'hFFFF) stall_cycles_d = stall_cycles_q;
    else                               stall_cycles_d = stall_cycles_q + 16'd1;
    hazard_timeout_d = hazard_timeout_q || (stall_cycles_d == 16'(MAX_STALL));
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pending_q        <= '0;
      tag_q            <= '0;
      pending_cnt_q    <= '0;
      stall_cycles_q   <= '0;
      hazard_timeout_q <= 1'b0;
    end else begin
      pending_q        <= pending_d;
      tag_q            <= tag_d;
      pending_cnt_q    <= pending_cnt_d;
      stall_cycles_q   <= stall_cycles_d;
      hazard_timeout_q <= hazard_timeout_d;
    end
  end

  assign pending_cnt    = pending_cnt_q;
  assign stall_cycles   = stall_cycles_q;
  assign hazard_timeout = hazard_timeout_q;
endmodule
